// File: rtl/ram_loader.sv
// ram_loader: framed byte-stream loader into program RAM, holds cpu in reset.
// Define RAM_LOADER_CHECKSUM_EN to require a trailing payload checksum byte.
module ram_loader #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    HEADER,
    LEN,
    LOAD,
`ifdef RAM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

`ifdef RAM_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHECK;
`else
  localparam state_t TAIL = DONE;
`endif
  localparam bit TAIL_DONE = (TAIL == DONE);
  localparam int LIMIT = (1 << ADDR_WIDTH) - 4;

  state_t                state;
  logic [1:0]            k;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            left;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]            sum;
`endif
  logic                  accept;

  assign accept = in_valid && in_ready;

  function automatic logic [7:0] magic(input logic [1:0] i);
    unique case (i)
      2'd0: magic = 8'h41;
      2'd1: magic = 8'h53;
      2'd2: magic = 8'h52;
      default: magic = 8'h4D;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HEADER;
      k         <= 2'd0;
      addr      <= '0;
      left      <= 8'd0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
      in_ready  <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        HEADER: if (accept) begin
          if (in_data == magic(k)) begin
            wr_en   <= 1'b1;
            wr_addr <= ADDR_WIDTH'(k);
            wr_data <= in_data;
            if (k == 2'd3) begin
              state <= LEN;
              k     <= 2'd0;
`ifdef RAM_LOADER_CHECKSUM_EN
              sum   <= 8'd0;
`endif
            end else begin
              k <= k + 2'd1;
            end
          end else if (in_data == 8'h41) begin
            // a stray 0x41 restarts the match rather than being dropped
            wr_en   <= 1'b1;
            wr_addr <= '0;
            wr_data <= in_data;
            k       <= 2'd1;
          end else begin
            k <= 2'd0;
          end
        end
        LEN: if (accept) begin
          left <= in_data;
          if (in_data == 8'd0) begin
            state     <= TAIL;
            in_ready  <= !TAIL_DONE;
            done      <= TAIL_DONE;
            cpu_reset <= !TAIL_DONE;
          end else if (int'(in_data) > LIMIT) begin
            state    <= ERROR;
            in_ready <= 1'b0;
            error    <= 1'b1;
          end else begin
            state <= LOAD;
            addr  <= ADDR_WIDTH'(4);
          end
        end
        LOAD: if (accept) begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= in_data;
          addr    <= addr + ADDR_WIDTH'(1);
          left    <= left - 8'd1;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum     <= sum + in_data;
`endif
          if (left == 8'd1) begin
            state     <= TAIL;
            in_ready  <= !TAIL_DONE;
            done      <= TAIL_DONE;
            cpu_reset <= !TAIL_DONE;
          end
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        CHECK: if (accept) begin
          in_ready <= 1'b0;
          if (in_data == sum) begin
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
`endif
        DONE, ERROR: if (restart) begin
          state     <= HEADER;
          k         <= 2'd0;
          in_ready  <= 1'b1;
          cpu_reset <= 1'b1;
          done      <= 1'b0;
          error     <= 1'b0;
        end
        default: state <= HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader (default ADDR_WIDTH = 7).
// Checksum cases run only when RAM_LOADER_CHECKSUM_EN is defined.
module tb_ram_loader;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          restart;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [7:0]  pl[$];

  ram_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_extra_write", {25'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("wr_addr", {25'd0, wr_addr}, {24'd0, e[15:8]});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic put(input logic [7:0] b, input bit w, input int a);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("wr_latency", {31'd0, wr_en}, {31'd0, w});
    if (w) sb.push_back({a[7:0], b});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wr_gap", {31'd0, wr_en}, 32'd0);
  endtask

  task automatic expect_end(input bit d, input bit e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("done", {31'd0, done}, {31'd0, d});
    chk("error", {31'd0, error}, {31'd0, e});
    chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, !d});
    chk("ready_end", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_ready", {31'd0, in_ready}, 32'd1);
    chk("rs_done", {31'd0, done}, 32'd0);
    chk("rs_error", {31'd0, error}, 32'd0);
    chk("rs_cpu_reset", {31'd0, cpu_reset}, 32'd1);
  endtask

  // sends magic, length, pl, checksum (+delta); stops after nstop bytes
  task automatic frame(input bit gap, input int nstop,
                       input logic [7:0] delta);
    logic [7:0] m[4];
    logic [7:0] s;
    m[0] = 8'h41; m[1] = 8'h53; m[2] = 8'h52; m[3] = 8'h4D;
    s = 8'd0;
    for (int i = 0; i < 4; i++) put(m[i], 1'b1, i);
    put(8'(pl.size()), 1'b0, 0);
    for (int i = 0; i < pl.size(); i++) begin
      if (i == nstop) return;
      put(pl[i], 1'b1, 4 + i);
      s = s + pl[i];
      if (gap) idle();
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    put(s + delta, 1'b0, 0);
`else
    s = s + delta;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;

    pl = '{8'hAA, 8'hBB, 8'hCC};
    frame(1'b0, -1, 8'd0);
    expect_end(1'b1, 1'b0);
    do_restart();

    put(8'h12, 1'b0, 0);
    put(8'h41, 1'b1, 0);
    put(8'h41, 1'b1, 0);
    put(8'h53, 1'b1, 1);
    put(8'h52, 1'b1, 2);
    put(8'h4D, 1'b1, 3);
    put(8'h00, 1'b0, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
    put(8'h00, 1'b0, 0);
`endif
    expect_end(1'b1, 1'b0);
    do_restart();

    for (int i = 0; i < 4; i++) begin
      logic [7:0] m;
      m = (i == 0) ? 8'h41 : (i == 1) ? 8'h53 : (i == 2) ? 8'h52 : 8'h4D;
      put(m, 1'b1, i);
    end
    put(8'h7D, 1'b0, 0);
    expect_end(1'b0, 1'b1);
    do_restart();

`ifdef RAM_LOADER_CHECKSUM_EN
    pl = '{8'h01, 8'h02};
    frame(1'b0, -1, 8'd1);
    expect_end(1'b0, 1'b1);
    do_restart();
    frame(1'b0, -1, 8'd0);
    expect_end(1'b1, 1'b0);
    do_restart();
`endif

    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom_range(0, 255)));
    frame(1'b1, -1, 8'd0);
    expect_end(1'b1, 1'b0);
    do_restart();

    pl.delete();
    for (int i = 0; i < 124; i++) pl.push_back(8'($urandom_range(0, 255)));
    frame(1'b0, -1, 8'd0);
    expect_end(1'b1, 1'b0);
    do_restart();

    pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    frame(1'b0, 3, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    frame(1'b0, -1, 8'd0);
    expect_end(1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
